w5300_bus_responder: RTL and testbench
======================================

// Module: w5300_bus_responder
// PURPOSE
//  Synthesizable W5300 chip-side model: the responder end of the W5300 16-bit parallel host bus.
//  Decodes cs_n/rd_n/wr_n/addr/data from a host bus master and serves a register file.
//  Models chip reset and PLL-lock timing; exposes a back-door port for firmware/bench.
//  Used for FPGA loopback bring-up and as the bus partner in host-interface simulations.
// PARAMETERS
//  CLK_FREQ   100  byte; clock in MHz, scaled against common::CLK_REF like all W5300 timing
//  REG_AW     6    register-file address width; depth = 2**REG_AW words at addr[REG_AW-1:0]
//  localparam RST_MIN_TICKS  = 100*CLK_FREQ/CLK_REF   (1us minimum w_rst_n low)
//  localparam PLL_LOCK_TICKS = 1000*CLK_FREQ/CLK_REF  (10us busy after reset release)
// PORTS
//  clk          in     1   system clock
//  rst_n        in     1   reset; one clock; synchronous, active-low
//  w_rst_n      in     1   chip reset pin from host, async to clk
//  cs_n         in     1   chip select, active-low
//  rd_n         in     1   read strobe, active-low
//  wr_n         in     1   write strobe, active-low
//  addr         in     10  word address from host
//  data         inout  16  bidirectional data bus
//  chip_ready   out    1   1 = Idle/Access states, bus serviced
//  wr_evt       out    1   1-cycle pulse per committed host write
//  wr_evt_addr  out    10  address of last committed host write
//  wr_evt_data  out    16  data of last committed host write
//  rd_evt       out    1   1-cycle pulse per serviced host read
//  proto_err    out    1   1-cycle pulse: rd_n and wr_n both low with cs_n low
//  bd_we        in     1   back-door write enable
//  bd_addr      in     REG_AW  back-door address
//  bd_wdata     in     16  back-door write data
//  bd_rdata     out    16  mem[bd_addr], registered, 1-cycle latency
//  bd_collision out    1   1-cycle pulse: bd write dropped, same-cycle host commit
// BEHAVIOUR
//  - rst_n low: all outputs 0; state = ChipReset; mem cleared; sync flops 1; bus released.
//  - w_rst_n/cs_n/rd_n/wr_n pass 2-FF synchronizers; addr, data sampled on clk each cycle.
//  - States: ChipReset, PllLock, Idle, WrAccess, RdAccess.
//  - ChipReset: counter runs while sync w_rst_n=0, saturating 16 bit. On release: count >=
//    RST_MIN_TICKS -> clear mem -> PllLock; else glitch -> previous state, mem kept.
//    From rst_n exit, first w_rst_n release always -> PllLock.
//  - Sync w_rst_n=0 in any state aborts access -> ChipReset; pending write dropped.
//  - PllLock: bus ignored, data hi-Z; after PLL_LOCK_TICKS -> Idle; chip_ready=1 from Idle.
//  - Idle: sync cs_n=0 & wr_n=0 & rd_n=1 -> WrAccess; cs_n=0 & rd_n=0 & wr_n=1 -> RdAccess.
//    Both strobes low -> proto_err pulse, stay Idle; repeats each cycle while held.
//  - WrAccess: addr/data re-captured every cycle strobe low; last sample kept. On sync wr_n
//    or cs_n high -> commit: mem write if addr < 2**REG_AW, else ignored.
//    Commit cycle: wr_evt=1, wr_evt_addr/data updated; next state Idle.
//  - RdAccess: entry cycle latches rd_q = lookup(addr), held for whole strobe; rd_evt pulse
//    on entry; exit to Idle when sync rd_n or cs_n high.
//  - lookup: addr < 2**REG_AW -> mem; addr == W5300::IDR_ADDR (10'h3FE) -> W5300::IDR_VAL
//    (16'h5300); otherwise 16'h0000. IDR is read-only; writes to it are ignored.
//  - Bus drive: data = rd_q when raw cs_n=0 & rd_n=0 & state==RdAccess, else 'z.
//    Raw pins, not synced, so release is immediate on strobe rise.
//  - Read latency: data valid 3 clk after rd_n fall; master strobe must be >= 4 clk.
//  - Back-door: bd_we writes mem any state except ChipReset clear cycle. Same cycle as host
//    commit to same index: host wins, bd_collision=1. Different index: both take effect.
//  - Back-door write vs host read latch, same index: rd_q gets pre-write value.
// STRUCTURE
//  - W5300 package gains IDR_ADDR and IDR_VAL; state enum stays local.
//  - Tick scaling reuses common::CLK_REF.
//  - Sub-module w5300_sync2: 2-FF sync, reset value 1; 4 instances (w_rst_n, cs_n, rd_n, wr_n).
// TESTING
//  1 Reset flow: w_rst_n low 200 clk, release -> chip_ready=0 for 1000 clk, then 1; mem reads 0.
//  2 Write/read: write 16'hA55A @10'h005, read 10'h005 -> 16'hA55A.
//    wr_evt=1 once, wr_evt_addr=10'h005; rd_evt=1 once.
//  3 Read 10'h3FE -> 16'h5300; write 16'h1234 to 10'h3FE, re-read -> still 16'h5300.
//  4 Read 10'h200 -> 16'h0000; write there -> no mem change, wr_evt still pulses.
//  5 Glitch/abort: w_rst_n low 50 clk -> mem kept, chip_ready back to 1.
//    w_rst_n low mid-write -> write dropped; no wr_evt.
//  6 Collision: bd_we @idx 5 in host commit cycle -> mem=host data, bd_collision=1.
//    Both strobes low -> proto_err, no mem change.

Source files
------------

// File: rtl/w5300_bus_responder_pkg.sv
// w5300_bus_responder_pkg: shared timing reference and identification register constants
package w5300_bus_responder_pkg;
  localparam int CLK_REF = 100;
  localparam logic [9:0] IDR_ADDR = 10'h3FE;
  localparam logic [15:0] IDR_VAL = 16'h5300;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/w5300_sync2.sv
// w5300_sync2: two-flop synchronizer with a reset value of 1 for idle-high pins
module w5300_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [1:0] ff_q, ff_d;
  always_comb ff_d = {ff_q[0], d};
  always_ff @(posedge clk) begin
    if (!rst_n) ff_q <= 2'b11;
    else ff_q <= ff_d;
  end
  assign q = ff_q[1];
endmodule

// File: rtl/w5300_bus_responder.sv
// w5300_bus_responder: chip-side W5300 host bus responder with chip reset/PLL timing and back-door port
module w5300_bus_responder
  import w5300_bus_responder_pkg::*;
#(
  parameter int CLK_FREQ = 100,
  parameter int REG_AW = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_rst_n,
  input  logic              cs_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [9:0]        addr,
  inout  wire logic [15:0]  data,
  output logic              chip_ready,
  output logic              wr_evt,
  output logic [9:0]        wr_evt_addr,
  output logic [15:0]       wr_evt_data,
  output logic              rd_evt,
  output logic              proto_err,
  input  logic              bd_we,
  input  logic [REG_AW-1:0] bd_addr,
  input  logic [15:0]       bd_wdata,
  output logic [15:0]       bd_rdata,
  output logic              bd_collision
);
  localparam logic [15:0] RST_MIN_TICKS = 16'(100 * CLK_FREQ / CLK_REF);
  localparam logic [15:0] PLL_LOCK_TICKS = 16'(1000 * CLK_FREQ / CLK_REF);
  localparam int DEPTH = 2 ** REG_AW;
  typedef enum logic [2:0] {CHIP_RESET, PLL_LOCK, IDLE, WR_ACCESS, RD_ACCESS} state_t;
  logic wrst_s, cs_s, rd_s, wr_s;
  state_t state_q, state_d, prev_q, prev_d;
  logic first_q, first_d;
  logic [15:0] cnt_q, cnt_d;
  logic [9:0] addr_q, addr_d, wa_q, wa_d, wr_evt_addr_q, wr_evt_addr_d;
  logic [15:0] din_q, din_d, wd_q, wd_d, rd_q, rd_d, wr_evt_data_q, wr_evt_data_d;
  logic [15:0] bd_rdata_q, bd_rdata_d, lookup;
  logic [15:0] mem_q [DEPTH], mem_d [DEPTH];
  logic chip_ready_q, chip_ready_d, wr_evt_q, wr_evt_d, rd_evt_q, rd_evt_d;
  logic proto_err_q, proto_err_d, bd_collision_q, bd_collision_d;
  logic clr, host_we;
  logic [REG_AW-1:0] host_idx;
  w5300_sync2 u_sync_rst (.clk(clk), .rst_n(rst_n), .d(w_rst_n), .q(wrst_s));
  w5300_sync2 u_sync_cs  (.clk(clk), .rst_n(rst_n), .d(cs_n),    .q(cs_s));
  w5300_sync2 u_sync_rd  (.clk(clk), .rst_n(rst_n), .d(rd_n),    .q(rd_s));
  w5300_sync2 u_sync_wr  (.clk(clk), .rst_n(rst_n), .d(wr_n),    .q(wr_s));
  function automatic logic in_rng(input logic [9:0] a);
    return (a >> REG_AW) == '0;
  endfunction
  assign lookup = in_rng(addr_q) ? mem_q[addr_q[REG_AW-1:0]] : (addr_q == IDR_ADDR ? IDR_VAL : 16'h0000);
  always_comb begin
    state_d = state_q;
    prev_d = prev_q;
    first_d = first_q;
    cnt_d = cnt_q;
    addr_d = addr;
    din_d = data;
    wa_d = wa_q;
    wd_d = wd_q;
    rd_d = rd_q;
    mem_d = mem_q;
    wr_evt_addr_d = wr_evt_addr_q;
    wr_evt_data_d = wr_evt_data_q;
    wr_evt_d = 1'b0;
    rd_evt_d = 1'b0;
    proto_err_d = 1'b0;
    bd_collision_d = 1'b0;
    bd_rdata_d = mem_q[bd_addr];
    clr = 1'b0;
    host_we = 1'b0;
    host_idx = wa_q[REG_AW-1:0];
    if (!wrst_s && state_q != CHIP_RESET) begin
      // Chip reset aborts any access; a glitch later resumes Idle rather than a half-done access
      state_d = CHIP_RESET;
      prev_d = (state_q == PLL_LOCK) ? PLL_LOCK : IDLE;
      cnt_d = 16'd1;
    end else begin
      case (state_q)
        CHIP_RESET:
          if (!wrst_s) cnt_d = sat_inc(cnt_q);
          else begin
            first_d = 1'b0;
            cnt_d = '0;
            clr = first_q || cnt_q >= RST_MIN_TICKS;
            state_d = clr ? PLL_LOCK : prev_q;
          end
        PLL_LOCK: begin
          cnt_d = (cnt_q == PLL_LOCK_TICKS - 16'd1) ? '0 : cnt_q + 16'd1;
          state_d = (cnt_q == PLL_LOCK_TICKS - 16'd1) ? IDLE : PLL_LOCK;
        end
        IDLE:
          if (!cs_s && !wr_s && rd_s) begin
            state_d = WR_ACCESS;
            wa_d = addr_q;
            wd_d = din_q;
          end else if (!cs_s && !rd_s && wr_s) begin
            state_d = RD_ACCESS;
            rd_d = lookup;
            rd_evt_d = 1'b1;
          end else proto_err_d = !cs_s && !rd_s && !wr_s;
        WR_ACCESS:
          if (!cs_s && !wr_s) begin
            wa_d = addr_q;
            wd_d = din_q;
          end else begin
            state_d = IDLE;
            host_we = in_rng(wa_q);
            wr_evt_d = 1'b1;
            wr_evt_addr_d = wa_q;
            wr_evt_data_d = wd_q;
          end
        RD_ACCESS: state_d = (cs_s || rd_s) ? IDLE : RD_ACCESS;
        default: state_d = CHIP_RESET;
      endcase
    end
    if (clr) mem_d = '{default: '0};
    else begin
      bd_collision_d = bd_we && host_we && host_idx == bd_addr;
      if (bd_we && !bd_collision_d) mem_d[bd_addr] = bd_wdata;
      if (host_we) mem_d[host_idx] = wd_q;
    end
    chip_ready_d = state_d == IDLE || state_d == WR_ACCESS || state_d == RD_ACCESS;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CHIP_RESET;
      prev_q <= CHIP_RESET;
      first_q <= 1'b1;
      cnt_q <= '0;
      addr_q <= '0;
      din_q <= '0;
      wa_q <= '0;
      wd_q <= '0;
      rd_q <= '0;
      mem_q <= '{default: '0};
      chip_ready_q <= 1'b0;
      wr_evt_q <= 1'b0;
      wr_evt_addr_q <= '0;
      wr_evt_data_q <= '0;
      rd_evt_q <= 1'b0;
      proto_err_q <= 1'b0;
      bd_rdata_q <= '0;
      bd_collision_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q <= prev_d;
      first_q <= first_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      din_q <= din_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
      rd_q <= rd_d;
      mem_q <= mem_d;
      chip_ready_q <= chip_ready_d;
      wr_evt_q <= wr_evt_d;
      wr_evt_addr_q <= wr_evt_addr_d;
      wr_evt_data_q <= wr_evt_data_d;
      rd_evt_q <= rd_evt_d;
      proto_err_q <= proto_err_d;
      bd_rdata_q <= bd_rdata_d;
      bd_collision_q <= bd_collision_d;
    end
  end
  // Raw pins gate the driver so the bus is released the instant the host lifts its strobe
  assign data = (!cs_n && !rd_n && state_q == RD_ACCESS) ? rd_q : 16'hzzzz;
  assign chip_ready = chip_ready_q;
  assign wr_evt = wr_evt_q;
  assign wr_evt_addr = wr_evt_addr_q;
  assign wr_evt_data = wr_evt_data_q;
  assign rd_evt = rd_evt_q;
  assign proto_err = proto_err_q;
  assign bd_rdata = bd_rdata_q;
  assign bd_collision = bd_collision_q;
endmodule

// File: tb/tb_w5300_bus_responder.sv
// tb_w5300_bus_responder: directed table, corner sequences and randomized traffic against a memory model
module tb_w5300_bus_responder;
  logic clk = 1'b0;
  logic rst_n, w_rst_n, cs_n, rd_n, wr_n, bd_we, drive;
  logic [9:0] addr;
  logic [15:0] dout, bd_wdata;
  logic [5:0] bd_addr;
  wire [15:0] data;
  logic chip_ready, wr_evt, rd_evt, proto_err, bd_collision;
  logic [9:0] wr_evt_addr;
  logic [15:0] wr_evt_data, bd_rdata;
  int checks = 0, errors = 0;
  int wr_cnt = 0, rd_cnt = 0, pe_cnt = 0;
  logic [15:0] model [64];
  assign data = drive ? dout : 16'hzzzz;
  always #5 clk = ~clk;
  w5300_bus_responder dut (
    .clk(clk), .rst_n(rst_n), .w_rst_n(w_rst_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .data(data), .chip_ready(chip_ready), .wr_evt(wr_evt),
    .wr_evt_addr(wr_evt_addr), .wr_evt_data(wr_evt_data), .rd_evt(rd_evt),
    .proto_err(proto_err), .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
    .bd_rdata(bd_rdata), .bd_collision(bd_collision)
  );
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_evt) wr_cnt <= wr_cnt + 1;
      if (rd_evt) rd_cnt <= rd_cnt + 1;
      if (proto_err) pe_cnt <= pe_cnt + 1;
    end
  end
  function automatic logic [15:0] ref_lookup(input logic [9:0] a);
    if (a < 10'd64) return model[a[5:0]];
    if (a == 10'h3FE) return 16'h5300;
    return 16'h0000;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic wait_ready(input string nm, input int budget, output int cyc);
    cyc = 0;
    while (!chip_ready && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!chip_ready) begin
      errors++;
      $display("FAIL %s: chip_ready still 0 after %0d cycles", nm, budget);
    end
  endtask
  task automatic host_wr(input logic [9:0] a, input logic [15:0] d, input logic bd_en,
                         input logic [5:0] bidx, input logic [15:0] bdat,
                         output logic coll, output logic evt);
    @(negedge clk);
    addr = a; dout = d; drive = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    repeat (2) @(negedge clk);
    bd_we = bd_en; bd_addr = bidx; bd_wdata = bdat;
    @(negedge clk);
    bd_we = 1'b0;
    coll = bd_collision; evt = wr_evt;
    repeat (2) @(negedge clk);
    drive = 1'b0;
    if (a < 10'd64) model[a[5:0]] = d;
    if (bd_en && !(a < 10'd64 && a[5:0] == bidx)) model[bidx] = bdat;
  endtask
  task automatic host_rd(input logic [9:0] a, output logic [15:0] v);
    @(negedge clk);
    addr = a; cs_n = 1'b0; rd_n = 1'b0;
    repeat (5) @(negedge clk);
    v = data;
    cs_n = 1'b1; rd_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic bd_rd(input logic [5:0] i, output logic [15:0] v);
    @(negedge clk);
    bd_addr = i;
    @(negedge clk);
    v = bd_rdata;
  endtask
  typedef struct {logic wr; logic [9:0] a; logic [15:0] d; logic [15:0] exp;} vec_t;
  vec_t tbl [10];
  initial begin
    int cyc, w0, r0, p0;
    logic [15:0] v;
    logic coll, evt;
    rst_n = 1'b0; w_rst_n = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    addr = '0; dout = '0; drive = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    for (int i = 0; i < 64; i++) model[i] = '0;
    tbl[0] = '{1'b1, 10'h005, 16'hA55A, 16'h0000};
    tbl[1] = '{1'b0, 10'h005, 16'h0000, 16'hA55A};
    tbl[2] = '{1'b0, 10'h3FE, 16'h0000, 16'h5300};
    tbl[3] = '{1'b1, 10'h3FE, 16'h1234, 16'h0000};
    tbl[4] = '{1'b0, 10'h3FE, 16'h0000, 16'h5300};
    tbl[5] = '{1'b0, 10'h200, 16'h0000, 16'h0000};
    tbl[6] = '{1'b1, 10'h200, 16'hBEEF, 16'h0000};
    tbl[7] = '{1'b0, 10'h200, 16'h0000, 16'h0000};
    tbl[8] = '{1'b1, 10'h007, 16'h0707, 16'h0000};
    tbl[9] = '{1'b0, 10'h03F, 16'h0000, 16'h0000};
    repeat (5) @(negedge clk);
    chk("rst_chip_ready", chip_ready, 0);
    chk("rst_wr_evt", wr_evt, 0);
    chk("rst_wr_evt_addr", wr_evt_addr, 0);
    chk("rst_rd_evt", rd_evt, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_bd_collision", bd_collision, 0);
    chk("rst_bd_rdata", bd_rdata, 0);
    rst_n = 1'b1;
    w_rst_n = 1'b0;
    repeat (200) @(negedge clk);
    chk("ready_in_chip_reset", chip_ready, 0);
    w_rst_n = 1'b1;
    wait_ready("pll_lock_timeout", 1100, cyc);
    checks++;
    if (cyc < 1000 || cyc > 1004) begin
      errors++;
      $display("FAIL pll_lock_delay: got %0d cycles expected 1000..1004", cyc);
    end
    bd_rd(6'd5, v);
    chk("mem_clear_bd5", v, 0);
    host_rd(10'h005, v);
    chk("mem_clear_host5", v, 0);
    for (int i = 0; i < 10; i++) begin
      w0 = wr_cnt; r0 = rd_cnt;
      if (tbl[i].wr) begin
        host_wr(tbl[i].a, tbl[i].d, 1'b0, 6'd0, 16'd0, coll, evt);
        chk($sformatf("tbl%0d_wr_evt_cnt", i), wr_cnt - w0, 1);
        chk($sformatf("tbl%0d_wr_evt_addr", i), wr_evt_addr, tbl[i].a);
        chk($sformatf("tbl%0d_wr_evt_data", i), wr_evt_data, tbl[i].d);
      end else begin
        host_rd(tbl[i].a, v);
        chk($sformatf("tbl%0d_rdata", i), v, tbl[i].exp);
        chk($sformatf("tbl%0d_rd_evt_cnt", i), rd_cnt - r0, 1);
      end
    end
    w_rst_n = 1'b0;
    repeat (50) @(negedge clk);
    chk("glitch_ready_low", chip_ready, 0);
    w_rst_n = 1'b1;
    wait_ready("glitch_recover", 20, cyc);
    host_rd(10'h005, v);
    chk("glitch_mem_kept", v, 16'hA55A);
    w0 = wr_cnt;
    @(negedge clk);
    addr = 10'h007; dout = 16'h7777; drive = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    w_rst_n = 1'b0;
    repeat (4) @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    repeat (20) @(negedge clk);
    w_rst_n = 1'b1; drive = 1'b0;
    wait_ready("abort_recover", 20, cyc);
    chk("abort_no_wr_evt", wr_cnt - w0, 0);
    host_rd(10'h007, v);
    chk("abort_write_dropped", v, 16'h0707);
    host_wr(10'h005, 16'hC0DE, 1'b1, 6'd5, 16'hBD00, coll, evt);
    chk("coll_wr_evt", evt, 1);
    chk("coll_flag", coll, 1);
    bd_rd(6'd5, v);
    chk("coll_host_wins", v, 16'hC0DE);
    host_wr(10'h00A, 16'h1111, 1'b1, 6'd9, 16'h2222, coll, evt);
    chk("nocoll_flag", coll, 0);
    bd_rd(6'd9, v);
    chk("nocoll_bd_data", v, 16'h2222);
    bd_rd(6'd10, v);
    chk("nocoll_host_data", v, 16'h1111);
    w0 = wr_cnt; r0 = rd_cnt; p0 = pe_cnt;
    @(negedge clk);
    addr = 10'h005; dout = 16'hFFFF; drive = 1'b1; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    repeat (3) @(negedge clk);
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    repeat (4) @(negedge clk);
    drive = 1'b0;
    chk("proto_err_cnt", pe_cnt - p0, 3);
    chk("proto_no_wr", wr_cnt - w0, 0);
    chk("proto_no_rd", rd_cnt - r0, 0);
    host_rd(10'h005, v);
    chk("proto_mem_kept", v, 16'hC0DE);
    for (int i = 0; i < 60; i++) begin
      int r;
      logic [9:0] a;
      r = $urandom_range(0, 9);
      a = (r < 7) ? 10'($urandom_range(0, 63)) : (r == 7) ? 10'h3FE : 10'($urandom_range(64, 1023));
      if ($urandom_range(0, 1) == 1) begin
        w0 = wr_cnt;
        host_wr(a, 16'($urandom), 1'b0, 6'd0, 16'd0, coll, evt);
        chk($sformatf("rnd%0d_wr_evt", i), wr_cnt - w0, 1);
      end else begin
        host_rd(a, v);
        chk($sformatf("rnd%0d_rd_%h", i, a), v, ref_lookup(a));
      end
    end
    for (int i = 0; i < 64; i += 4) begin
      bd_rd(6'(i), v);
      chk($sformatf("final_bd_%0d", i), v, model[i]);
    end
    chk("final_ready", chip_ready, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
